// File: rtl/riscv_mul_pipe.sv
// Pipelined RV32M/RV64M multiplier (MUL/MULH/MULHSU/MULHU/MULW) with tag,
// valid/ready back-pressure and synchronous flush; results return in order.
module riscv_mul_pipe #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       in_op_i,
    input  logic             in_word_i,
    input  logic [XLEN-1:0]  in_opa_i,
    input  logic [XLEN-1:0]  in_opb_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  out_r_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             busy_o
);

    // Out-of-range latencies are clamped to the nearest legal value.
    localparam int LAT = (LATENCY < 1) ? 1 : ((LATENCY > 4) ? 4 : LATENCY);
    localparam int PW  = 2 * XLEN;

    typedef struct packed {
        logic [1:0]       op;
        logic             word;
        logic [TAG_W-1:0] tag;
    } meta_t;

    logic [LAT:0]    vld_q;
    meta_t           meta_q [LAT:0];
    logic [XLEN-1:0] ma_q, mb_q;
    logic            neg_q;
    logic [PW-1:0]   prod_q [LAT:1];

    logic            adv;
    logic            word_d, sa, sb, neg_d;
    logic [XLEN-1:0] ax, bx, ma_d, mb_d;
    logic [PW-1:0]   umul, prod_d, p_out;

    // The whole pipe advances or freezes as one unit.
    assign adv        = !(vld_q[LAT] && !out_ready_i);
    assign in_ready_o = !flush_i && adv;

    // Operand conditioning: magnitudes plus the sign of the final product.
    always_comb begin
        word_d = (XLEN == 64) && in_word_i && (in_op_i == 2'b00);
        ax     = word_d ? XLEN'($signed(in_opa_i[31:0])) : in_opa_i;
        bx     = word_d ? XLEN'($signed(in_opb_i[31:0])) : in_opb_i;
        sa     = ax[XLEN-1];
        sb     = bx[XLEN-1];
        ma_d   = ((in_op_i == 2'b11) || !sa) ? ax : -ax;
        mb_d   = (in_op_i[1] || !sb) ? bx : -bx;
        neg_d  = 1'b0;
        case (in_op_i)
            2'b00, 2'b01: neg_d = sa ^ sb;
            2'b10:        neg_d = sa;
            default:      neg_d = 1'b0;
        endcase
    end

    assign umul   = PW'(ma_q) * PW'(mb_q);
    assign prod_d = neg_q ? -umul : umul;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            vld_q <= '0;
        else if (flush_i)
            vld_q <= '0;
        else if (adv)
            vld_q <= {vld_q[LAT-1:0], in_valid_i && in_ready_o};
    end

    // Data stages carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (adv) begin
            ma_q      <= ma_d;
            mb_q      <= mb_d;
            neg_q     <= neg_d;
            meta_q[0] <= '{op: in_op_i, word: word_d, tag: in_tag_i};
            prod_q[1] <= prod_d;
            for (int i = 1; i <= LAT; i++)
                meta_q[i] <= meta_q[i-1];
            for (int i = 2; i <= LAT; i++)
                prod_q[i] <= prod_q[i-1];
        end
    end

    assign p_out = prod_q[LAT];

    always_comb begin
        out_r_o = p_out[PW-1:XLEN];
        if (meta_q[LAT].op == 2'b00)
            out_r_o = meta_q[LAT].word ? XLEN'($signed(p_out[31:0])) : p_out[XLEN-1:0];
    end

    assign out_valid_o = vld_q[LAT];
    assign out_tag_o   = meta_q[LAT].tag;
    assign busy_o      = |vld_q;

endmodule

// File: tb/tb_riscv_mul_pipe.sv
// Directed and table-driven checks of riscv_mul_pipe: a 32-bit LATENCY=2 unit
// plus a 64-bit sweep of LATENCY 1..4 against a signed-arithmetic model.
module tb_riscv_mul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    // 32-bit, LATENCY=2 unit
    logic        a_flush, a_iv, a_ir, a_w, a_ov, a_ordy, a_busy;
    logic [1:0]  a_op;
    logic [31:0] a_a, a_b, a_r;
    logic [4:0]  a_tag, a_otag;

    riscv_mul_pipe #(.XLEN(32), .LATENCY(2), .TAG_W(5)) u_dut32 (
        .clk(clk), .rstn(rstn), .flush_i(a_flush),
        .in_valid_i(a_iv), .in_ready_o(a_ir), .in_op_i(a_op), .in_word_i(a_w),
        .in_opa_i(a_a), .in_opb_i(a_b), .in_tag_i(a_tag),
        .out_valid_o(a_ov), .out_ready_i(a_ordy), .out_r_o(a_r),
        .out_tag_o(a_otag), .busy_o(a_busy)
    );

    // 64-bit units with LATENCY 1..4 sharing one input stream
    logic        s_flush, s_iv, s_w, s_ordy;
    logic [1:0]  s_op;
    logic [63:0] s_a, s_b;
    logic [4:0]  s_tag;
    logic        sw_ir [1:4];
    logic        sw_ov [1:4];
    logic        sw_busy [1:4];
    logic [63:0] sw_r [1:4];
    logic [4:0]  sw_tg [1:4];

    for (genvar g = 1; g <= 4; g++) begin : g_sweep
        riscv_mul_pipe #(.XLEN(64), .LATENCY(g), .TAG_W(5)) u_dut64 (
            .clk(clk), .rstn(rstn), .flush_i(s_flush),
            .in_valid_i(s_iv), .in_ready_o(sw_ir[g]), .in_op_i(s_op), .in_word_i(s_w),
            .in_opa_i(s_a), .in_opb_i(s_b), .in_tag_i(s_tag),
            .out_valid_o(sw_ov[g]), .out_ready_i(s_ordy), .out_r_o(sw_r[g]),
            .out_tag_o(sw_tg[g]), .busy_o(sw_busy[g])
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: full-width signed/unsigned products, then select.
    function automatic logic [63:0] ref_mul(input int xl, input logic [1:0] op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb, ua, ub, p;
        logic [63:0] r;
        if (xl == 32 || (op == 2'd0 && w)) begin
            sa = {{96{a[31]}}, a[31:0]};
            sb = {{96{b[31]}}, b[31:0]};
            ua = {96'd0, a[31:0]};
            ub = {96'd0, b[31:0]};
        end else begin
            sa = {{64{a[63]}}, a};
            sb = {{64{b[63]}}, b};
            ua = {64'd0, a};
            ub = {64'd0, b};
        end
        case (op)
            2'd0, 2'd1: p = sa * sb;
            2'd2:       p = sa * ub;
            default:    p = ua * ub;
        endcase
        if (op == 2'd0)
            r = (xl == 32) ? {32'd0, p[31:0]} : (w ? {{32{p[31]}}, p[31:0]} : p[63:0]);
        else
            r = (xl == 32) ? {32'd0, p[63:32]} : p[127:64];
        return r;
    endfunction

    // Issue one op; which=0 -> 32-bit unit, which=1 -> 64-bit LATENCY=3 unit.
    task automatic single(input int which, input vec_t v, input logic [4:0] tag, input string name);
        int lat;
        int want;
        logic ov;
        @(negedge clk);
        if (which == 0) begin
            a_iv = 1'b1; a_op = v.op; a_w = v.w; a_a = v.a[31:0]; a_b = v.b[31:0];
            a_tag = tag; a_ordy = 1'b1;
        end else begin
            s_iv = 1'b1; s_op = v.op; s_w = v.w; s_a = v.a; s_b = v.b; s_tag = tag;
        end
        #1;
        chk({name, " in_ready"}, (which == 0) ? a_ir : sw_ir[3], 1);
        @(negedge clk);
        a_iv = 1'b0;
        s_iv = 1'b0;
        chk({name, " busy"}, (which == 0) ? a_busy : sw_busy[3], 1);
        lat  = 0;
        want = (which == 0) ? 2 : 3;
        ov   = (which == 0) ? a_ov : sw_ov[3];
        while (!ov && lat < 10) begin
            @(negedge clk);
            lat++;
            ov = (which == 0) ? a_ov : sw_ov[3];
        end
        chk({name, " latency"}, lat, want);
        if (which == 0) begin
            chk({name, " result"}, {32'd0, a_r}, v.exp);
            chk({name, " tag"}, a_otag, tag);
        end else begin
            chk({name, " result"}, sw_r[3], v.exp);
            chk({name, " tag"}, sw_tg[3], tag);
        end
    endtask

    vec_t v32 [9];
    vec_t v64 [6];

    initial begin
        rstn = 1'b0;
        a_flush = 0; a_iv = 0; a_w = 0; a_ordy = 1; a_op = 0; a_a = 0; a_b = 0; a_tag = 0;
        s_flush = 0; s_iv = 0; s_w = 0; s_ordy = 1; s_op = 0; s_a = 0; s_b = 0; s_tag = 0;

        v32[0] = '{2'd0, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000001};
        v32[1] = '{2'd1, 1'b0, 64'h80000000, 64'h80000000, 64'h40000000};
        v32[2] = '{2'd2, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF};
        v32[3] = '{2'd3, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE};
        v32[4] = '{2'd0, 1'b0, 64'h00000007, 64'h00000006, 64'h0000002A};
        v32[5] = '{2'd1, 1'b0, 64'h7FFFFFFF, 64'h7FFFFFFF, 64'h3FFFFFFF};
        v32[6] = '{2'd1, 1'b0, 64'hFFFFFFFF, 64'h00000001, 64'hFFFFFFFF};
        v32[7] = '{2'd3, 1'b0, 64'h80000000, 64'h00000002, 64'h00000001};
        v32[8] = '{2'd0, 1'b1, 64'h00010000, 64'h00010000, 64'h00000000};

        v64[0] = '{2'd0, 1'b1, 64'h00000000_7FFFFFFF, 64'h2, 64'hFFFFFFFF_FFFFFFFE};
        v64[1] = '{2'd1, 1'b1, 64'h80000000_00000000, 64'h80000000_00000000, 64'h40000000_00000000};
        v64[2] = '{2'd0, 1'b1, 64'hFFFFFFFF_00000003, 64'h5, 64'h00000000_0000000F};
        v64[3] = '{2'd0, 1'b1, 64'h12345678_80000000, 64'h1, 64'hFFFFFFFF_80000000};
        v64[4] = '{2'd3, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFE};
        v64[5] = '{2'd2, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'h2, 64'hFFFFFFFF_FFFFFFFF};

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("reset out_valid", a_ov, 0);
        chk("reset busy", a_busy, 0);
        chk("reset in_ready", a_ir, 1);
        for (int g = 1; g <= 4; g++) begin
            chk($sformatf("reset L%0d valid/busy/ready", g), {sw_ov[g], sw_busy[g], sw_ir[g]}, 3'b001);
        end

        for (int i = 0; i < 9; i++) single(0, v32[i], 5'(i), $sformatf("v32[%0d]", i));
        for (int i = 0; i < 6; i++) single(1, v64[i], 5'(i + 16), $sformatf("v64[%0d]", i));

        // Back-to-back stream with out_ready pattern 1,0,0,1
        begin
            logic [31:0] sa_v [8];
            logic [31:0] sb_v [8];
            logic [31:0] sexp [8];
            logic [31:0] hold_r;
            logic [4:0]  hold_t;
            logic        stalled;
            int sent, got, cyc;
            for (int i = 0; i < 8; i++) begin
                sa_v[i] = 32'hDEAD0000 ^ (32'(i) * 32'h01F311A7);
                sb_v[i] = 32'h8000_0001 + 32'(i) * 32'h1357_9BDF;
                sexp[i] = ref_mul(32, 2'(i % 4), 1'b0, {32'd0, sa_v[i]}, {32'd0, sb_v[i]})[31:0];
            end
            sent = 0; got = 0; cyc = 0; stalled = 0; hold_r = 0; hold_t = 0;
            while (got < 8 && cyc < 200) begin
                @(negedge clk);
                if (stalled) begin
                    chk("stream stall valid", a_ov, 1);
                    chk("stream stall r", a_r, hold_r);
                    chk("stream stall tag", a_otag, hold_t);
                end
                a_ordy = (cyc % 4 == 0) || (cyc % 4 == 3);
                a_iv   = (sent < 8);
                a_op   = 2'(sent % 4);
                a_w    = 1'b0;
                a_a    = (sent < 8) ? sa_v[sent] : 32'd0;
                a_b    = (sent < 8) ? sb_v[sent] : 32'd0;
                a_tag  = 5'(sent);
                #1;
                chk("stream in_ready", a_ir, !(a_ov && !a_ordy));
                if (a_iv && a_ir) sent++;
                if (a_ov && a_ordy) begin
                    chk($sformatf("stream tag %0d", got), a_otag, 5'(got));
                    chk($sformatf("stream r %0d", got), a_r, sexp[got]);
                    got++;
                end
                stalled = a_ov && !a_ordy;
                hold_r  = a_r;
                hold_t  = a_otag;
                cyc++;
            end
            chk("stream count", got, 8);
            a_iv = 1'b0;
            a_ordy = 1'b1;
        end

        // Flush with two ops in flight and a request in the flush cycle
        begin
            logic seen;
            seen = 1'b0;
            @(negedge clk);
            a_iv = 1; a_op = 0; a_w = 0; a_a = 3; a_b = 5; a_tag = 10;
            @(negedge clk);
            a_tag = 11; a_a = 7;
            seen = seen | a_ov;
            @(negedge clk);
            a_tag = 12; a_flush = 1;
            #1;
            chk("flush in_ready", a_ir, 0);
            seen = seen | a_ov;
            @(negedge clk);
            a_flush = 0; a_iv = 0;
            for (int i = 0; i < 6; i++) begin
                seen = seen | a_ov;
                @(negedge clk);
            end
            chk("flush no output", seen, 0);
            chk("flush busy", a_busy, 0);
            single(0, v32[4], 5'd13, "post-flush");
        end

        // Asynchronous reset with a full, stalled pipe
        begin
            logic seen;
            seen = 1'b0;
            @(negedge clk);
            a_ordy = 0; a_iv = 1; a_op = 3; a_a = 32'h1234; a_b = 32'h10; a_tag = 20;
            repeat (5) @(negedge clk);
            chk("pre-reset full", {a_ov, a_busy, a_ir}, 3'b110);
            #2 rstn = 1'b0;
            #1;
            chk("async reset out_valid", a_ov, 0);
            chk("async reset busy", a_busy, 0);
            @(negedge clk);
            rstn = 1'b1; a_iv = 0; a_ordy = 1;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                seen = seen | a_ov;
            end
            chk("post-reset no stale", seen, 0);
            chk("post-reset in_ready", a_ir, 1);
        end

        // LATENCY 1..4 sweep: corner operand grid, then random ops with bubbles
        begin
            localparam int NC = 7 * 7 * 5;
            localparam int NOPS = NC + 200;
            logic [63:0] corner [7];
            logic        hv [NOPS];
            logic [63:0] hexp [NOPS];
            logic [4:0]  htg [NOPS];
            logic        ev;
            int k;
            corner[0] = 64'd0;
            corner[1] = 64'd1;
            corner[2] = '1;
            corner[3] = 64'h80000000_00000000;
            corner[4] = 64'h7FFFFFFF_FFFFFFFF;
            corner[5] = 64'h00000000_80000000;
            corner[6] = 64'h00000000_7FFFFFFF;
            repeat (6) @(negedge clk);
            for (int c = 0; c < NOPS + 6; c++) begin
                @(negedge clk);
                for (int l = 1; l <= 4; l++) begin
                    k  = c - l - 1;
                    ev = (k >= 0 && k < NOPS) ? hv[k] : 1'b0;
                    chk($sformatf("sweep L%0d valid c%0d", l, c), sw_ov[l], ev);
                    if (ev && sw_ov[l]) begin
                        chk($sformatf("sweep L%0d r c%0d", l, c), sw_r[l], hexp[k]);
                        chk($sformatf("sweep L%0d tag c%0d", l, c), sw_tg[l], htg[k]);
                    end
                end
                if (c < NC) begin
                    s_iv = 1'b1;
                    s_a  = corner[c % 7];
                    s_b  = corner[(c / 7) % 7];
                    s_op = (c / 49 == 4) ? 2'd0 : 2'(c / 49);
                    s_w  = (c / 49 == 4);
                end else if (c < NOPS) begin
                    s_iv = ($urandom_range(0, 3) != 0);
                    s_a  = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 6)] : {$urandom, $urandom};
                    s_b  = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 6)] : {$urandom, $urandom};
                    s_op = 2'($urandom_range(0, 3));
                    s_w  = 1'($urandom_range(0, 1));
                end else begin
                    s_iv = 1'b0;
                end
                s_tag = 5'(c);
                if (c < NOPS) begin
                    hv[c]   = s_iv;
                    hexp[c] = ref_mul(64, s_op, s_w, s_a, s_b);
                    htg[c]  = 5'(c);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
